my_alu: RTL and testbench

- Handshaked, multi-cycle unsigned ALU with operand width N.
- Four operations: add-with-carry, subtract, multiply and bitwise AND. All additions go through a carry-lookahead adder sub-module.
- Sits beside the instruction ROM. The controller feeds it cmd/op1/op2 decoded from an 18-bit command word ({cmd[1:0], op1[7:0], op2[7:0]}) and counts completed operations on ack.
- The ROM and the controller are out of scope for this block.

---
 rtl/my_alu_pkg.sv | 26 ++
 rtl/my_alu_cla_adder.sv | 52 +++++
 rtl/my_alu.sv | 216 +++++++++++++++++++++
 tb/tb_my_alu.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/my_alu_pkg.sv
// -----------------------------------------------------------------------------
// my_alu_pkg
// Shared definitions for the my_alu handshaked ALU and its carry-lookahead
// adder: default operand width, opcode encoding and FSM state encoding.
// -----------------------------------------------------------------------------
package my_alu_pkg;

    // Default operand width; results are twice this wide.
    localparam int DEF_N = 8;

    // Opcode encoding as carried in cmd[1:0] of the controller's command word.
    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        MUL = 2'b10,
        AND = 2'b11
    } op_e;

    // Operation sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/my_alu_cla_adder.sv
// -----------------------------------------------------------------------------
// cla_adder
// Purely combinational n-bit carry-lookahead adder. Every carry is formed
// directly from the generate/propagate terms and cin rather than rippling
// through the lower carries.
//
// Ports:
//   a, b  [n-1:0]  addends
//   cin            carry-in
//   sum   [n-1:0]  a + b + cin, modulo 2^n
//   cout           carry out of bit n-1
// -----------------------------------------------------------------------------
module cla_adder #(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);

    logic [n-1:0] g;
    logic [n-1:0] p;
    logic [n:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
    always_comb begin
        logic carry;
        logic term_p;
        c     = '0;
        c[0]  = cin;
        carry = 1'b0;
        term_p = 1'b0;
        for (int i = 0; i < n; i++) begin
            carry  = g[i];
            term_p = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                carry  = carry | (term_p & g[j]);
                term_p = term_p & p[j];
            end
            c[i+1] = carry | (term_p & cin);
        end
    end

    assign sum  = p ^ c[n-1:0];
    assign cout = c[n];

endmodule

// File: rtl/my_alu.sv
// -----------------------------------------------------------------------------
// my_alu
// Handshaked multi-cycle unsigned ALU: ADD (with carry-in), SUB, MUL
// (N-step shift-add) and bitwise AND. One shared 2N-bit carry-lookahead adder
// serves ADD, SUB and every MUL accumulate step through an input mux.
// Operands are latched when a request is accepted in IDLE, so input changes
// during CALC/DONE have no effect.
//
// Optional build macro: MY_ALU_BUSY_OUT_EN adds a registered busy output that
// is high whenever the sequencer is not in IDLE.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, aborts any operation in flight
//   req      operation request, only sampled in IDLE
//   cin      carry-in, used by ADD only
//   op1, op2 [N-1:0] unsigned operands
//   cmd      [1:0] opcode (00 ADD, 01 SUB, 10 MUL, 11 AND)
//   busy     (MY_ALU_BUSY_OUT_EN only) high while an operation is in progress
//   alu_out  [2N-1:0] registered result, held until the next result
//   ack      one-cycle registered completion pulse
// -----------------------------------------------------------------------------
module my_alu
    import my_alu_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic           cin,
    input  logic [N-1:0]   op1,
    input  logic [N-1:0]   op2,
    input  logic [1:0]     cmd,
`ifdef MY_ALU_BUSY_OUT_EN
    output logic           busy,
`endif
    output logic [2*N-1:0] alu_out,
    output logic           ack
);

    localparam int SW = (N > 1) ? $clog2(N) : 1;

    state_e         state_q,   state_d;
    logic [N-1:0]   op1_q,     op1_d;
    logic [N-1:0]   op2_q,     op2_d;     // doubles as the shifting multiplier
    logic [1:0]     cmd_q,     cmd_d;
    logic           cin_q,     cin_d;
    logic [2*N-1:0] acc_q,     acc_d;
    logic [SW-1:0]  step_q,    step_d;
    logic [2*N-1:0] alu_out_q, alu_out_d;
    logic           ack_q,     ack_d;
`ifdef MY_ALU_BUSY_OUT_EN
    logic           busy_q,    busy_d;
`endif

    // Shared adder operands and result.
    logic [2*N-1:0] add_a;
    logic [2*N-1:0] add_b;
    logic           add_cin;
    logic [2*N-1:0] add_sum;
    logic           add_cout_unused;   // 2N-bit sums never overflow here

    logic [2*N-1:0] mcand_shifted;
    logic [2*N-1:0] single_result;

    assign mcand_shifted = {{N{1'b0}}, op1_q} << step_q;

    // Adder input mux: the latched opcode selects which operation owns it.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (cmd_q)
            ADD: begin
                add_a   = {{N{1'b0}}, op1_q};
                add_b   = {{N{1'b0}}, op2_q};
                add_cin = cin_q;
            end
            SUB: begin
                // Two's-complement subtract; bit N of the sum is the
                // no-borrow flag because ~op2 is only N bits wide.
                add_a   = {{N{1'b0}}, op1_q};
                add_b   = {{N{1'b0}}, ~op2_q};
                add_cin = 1'b1;
            end
            MUL: begin
                add_a   = acc_q;
                add_b   = op2_q[0] ? mcand_shifted : '0;
                add_cin = 1'b0;
            end
            default: begin
                add_a   = '0;
                add_b   = '0;
                add_cin = 1'b0;
            end
        endcase
    end

    cla_adder #(
        .n   (2 * N)
    ) u_cla (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum),
        .cout(add_cout_unused)
    );

    // Result of the single-cycle operations.
    always_comb begin
        single_result = '0;
        case (cmd_q)
            ADD:     single_result = add_sum;
            SUB:     single_result = {{(N-1){1'b0}}, add_sum[N:0]};
            AND:     single_result = {{N{1'b0}}, op1_q & op2_q};
            default: single_result = '0;
        endcase
    end

    // Sequencer next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        cmd_d     = cmd_q;
        cin_d     = cin_q;
        acc_d     = acc_q;
        step_d    = step_q;
        alu_out_d = alu_out_q;
        ack_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    op1_d   = op1;
                    op2_d   = op2;
                    cmd_d   = cmd;
                    cin_d   = cin;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cmd_q == MUL) begin
                    acc_d  = add_sum;
                    op2_d  = op2_q >> 1;
                    step_d = step_q + SW'(1);
                    // The final partial product is folded straight into the
                    // result so the product is ready on the N-th step.
                    if (step_q == SW'(N - 1)) begin
                        alu_out_d = add_sum;
                        ack_d     = 1'b1;
                        state_d   = DONE;
                    end
                end else begin
                    alu_out_d = single_result;
                    ack_d     = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // No capture from DONE: a held req is taken on the next IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef MY_ALU_BUSY_OUT_EN
    assign busy_d = (state_d != IDLE);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op1_q     <= '0;
            op2_q     <= '0;
            cmd_q     <= '0;
            cin_q     <= 1'b0;
            acc_q     <= '0;
            step_q    <= '0;
            alu_out_q <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            cmd_q     <= cmd_d;
            cin_q     <= cin_d;
            acc_q     <= acc_d;
            step_q    <= step_d;
            alu_out_q <= alu_out_d;
            ack_q     <= ack_d;
        end
    end

`ifdef MY_ALU_BUSY_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`endif

    assign alu_out = alu_out_q;
    assign ack     = ack_q;

endmodule

// File: tb/tb_my_alu.sv
// -----------------------------------------------------------------------------
// tb_my_alu
// Directed bench for my_alu. Expected results and latencies are queued when
// an operation is issued and popped when ack is observed.
// -----------------------------------------------------------------------------
module tb_my_alu;
    import my_alu_pkg::*;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           req;
    logic           cin;
    logic [N-1:0]   op1;
    logic [N-1:0]   op2;
    logic [1:0]     cmd;
    logic [2*N-1:0] alu_out;
    logic           ack;
`ifdef MY_ALU_BUSY_OUT_EN
    logic           busy;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    my_alu #(
        .N      (N)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .cin    (cin),
        .op1    (op1),
        .op2    (op2),
        .cmd    (cmd),
`ifdef MY_ALU_BUSY_OUT_EN
        .busy   (busy),
`endif
        .alu_out(alu_out),
        .ack    (ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of the ALU, written from the result formats.
    function automatic logic [15:0] model(input logic [1:0] c, input logic [7:0] a,
                                          input logic [7:0] b, input logic ci);
        logic [8:0] diff;
        case (c)
            2'b00:   return 16'(a) + 16'(b) + 16'(ci);
            2'b01: begin
                diff = {1'b0, a} + {1'b0, ~b} + 9'd1;
                return {7'd0, diff};
            end
            2'b10:   return 16'(a) * 16'(b);
            default: return {8'd0, a & b};
        endcase
    endfunction

    // Issue one operation, scramble the inputs after capture, wait for ack.
    task automatic run_op(input string tag, input logic [1:0] c, input logic [7:0] a,
                          input logic [7:0] b, input logic ci, input logic [15:0] exp_res);
        exp_t e;
        int   lat;
        bit   got;
        logic [15:0] held;
        sb.push_back('{exp_res, (c == MUL) ? N + 1 : 2});
        @(negedge clk);
        cmd = c; op1 = a; op2 = b; cin = ci; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0; op1 = ~a; op2 = ~b; cmd = ~c; cin = ~ci;
`ifdef MY_ALU_BUSY_OUT_EN
        check({tag, " busy_set"}, busy, 1'b1);
`endif
        lat = 1;   // the capture edge counts as the first
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, " ack_seen"}, got, 1'b1);
        e = sb.pop_front();
        if (got) begin
            check({tag, " latency"}, lat, e.lat);
            check({tag, " result"}, alu_out, e.res);
            held = alu_out;
            @(posedge clk);
            #1;
            check({tag, " ack_pulse"}, ack, 1'b0);
            check({tag, " hold"}, alu_out, held);
`ifdef MY_ALU_BUSY_OUT_EN
            check({tag, " busy_clr"}, busy, 1'b0);
`endif
        end
    endtask

    initial begin
        int   gap;
        bit   got;
        bit   saw_ack;
        logic [1:0] rc;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rci;

        rst = 1'b1; req = 1'b0; cin = 1'b0; op1 = '0; op2 = '0; cmd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset alu_out", alu_out, 16'h0000);
        check("reset ack", ack, 1'b0);
`ifdef MY_ALU_BUSY_OUT_EN
        check("reset busy", busy, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Directed operations.
        run_op("add_cin",  ADD, 8'h7F, 8'h01, 1'b1, 16'h0081);
        run_op("add_cout", ADD, 8'hFF, 8'h01, 1'b0, 16'h0100);
        run_op("sub_borr", SUB, 8'h05, 8'h07, 1'b1, 16'h00FE);
        run_op("sub_ok",   SUB, 8'h07, 8'h05, 1'b0, 16'h0102);
        run_op("mul_max",  MUL, 8'hFF, 8'hFF, 1'b1, 16'hFE01);
        run_op("mul_zero", MUL, 8'h00, 8'hAB, 1'b0, 16'h0000);
        run_op("and_iso",  AND, 8'hF0, 8'h3C, 1'b1, 16'h0030);

        // Random operations against the reference model.
        for (int k = 0; k < 6; k++) begin
            rc  = 2'($urandom_range(0, 3));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rci = 1'($urandom);
            run_op($sformatf("rand%0d", k), rc, ra, rb, rci, model(rc, ra, rb, rci));
        end

        // Held req: next capture only after DONE -> IDLE, so acks are 3 edges apart.
        @(negedge clk);
        cmd = ADD; op1 = 8'h03; op2 = 8'h04; cin = 1'b0; req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        check("b2b first_ack", got, 1'b1);
        check("b2b first_result", alu_out, 16'h0007);
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            gap++;
            if (ack) break;
        end
        check("b2b ack_gap", gap, 3);
        check("b2b second_result", alu_out, 16'h0007);
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(posedge clk);

        // Reset during the 4th CALC cycle of a multiply.
        @(negedge clk);
        cmd = MUL; op1 = 8'h12; op2 = 8'h34; cin = 1'b0; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort alu_out", alu_out, 16'h0000);
        check("abort ack", ack, 1'b0);
`ifdef MY_ALU_BUSY_OUT_EN
        check("abort busy", busy, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;
        saw_ack = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (ack) saw_ack = 1'b1;
        end
        check("abort no_ack", saw_ack, 1'b0);
        check("abort alu_out_idle", alu_out, 16'h0000);

        run_op("mul_after", MUL, 8'h12, 8'h34, 1'b0, 16'h03A8);

        check("scoreboard empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
